freq_meas_sequencer: RTL and testbench
======================================

// Module: freq_meas_sequencer
// PURPOSE
//  Sequences one gated frequency measurement of the unknown clock i_fx (e.g. divided test clock clk_div).
//  Opens a gate window of a selectable number of clkout_50m cycles and counts i_fx rising edges inside it.
//  Presents the count to the UART/display formatter over a valid/ready handshake.
//  Supports single-shot (i_start) and continuous (i_auto) operation, plus abort.
//  Sits between the test-clock source and the control/report logic, all in the clkout_50m domain.
// PARAMETERS
//  CNT_W   32          width of edge counter and o_count
//  GATE0   50_000_000  gate length in clkout_50m cycles for i_gate_sel=0 (1 s)
//  GATE1   5_000_000   gate length for i_gate_sel=1 (100 ms)
//  GATE2   500_000     gate length for i_gate_sel=2 (10 ms)
//  GATE3   50_000      gate length for i_gate_sel=3 (1 ms); all GATEn >= 2
// PORTS
//  clkout_50m   in   1      system clock, 50 MHz
//  grst_n       in   1      reset, asynchronous, active-low
//  i_fx         in   1      clock under test, asynchronous to clkout_50m
//  i_start      in   1      1-cycle request for one measurement
//  i_auto       in   1      level: restart automatically after each accepted result
//  i_abort      in   1      1-cycle: cancel measurement in progress, no result
//  i_gate_sel   in   2      gate-length select, sampled in ARM
//  i_ready      in   1      consumer accepts result when high with o_valid
//  o_valid      out  1      result available
//  o_count      out  CNT_W  rising edges of i_fx counted in gate window
//  o_ovf        out  1      counter saturated during this result's gate (valid with o_valid)
//  o_gate       out  1      high exactly during GATE state
//  o_busy       out  1      high in ARM, GATE, DONE
// BEHAVIOUR
//  Reset (grst_n low, async): state IDLE; o_valid, o_count, o_ovf, o_gate, o_busy = 0; sync flops = 0.
//  Input path: i_fx -> 2-flop synchroniser -> delay flop; edge strobe = sync2 & ~dly (3-cycle latency).
//   Measurable range: fx < 25 MHz, high/low each >= 1 clk period; beyond that, edges are lost (not an error).
//  FSM:
//   IDLE: o_busy=0. i_start or i_auto -> ARM.
//   ARM (1 cycle): edge counter <= 0; timer <= GATEsel-1 (i_gate_sel latched here); ovf flag <= 0 -> GATE.
//   GATE: o_gate=1; each edge strobe increments counter; timer decrements each cycle.
//    Exactly GATEsel cycles in GATE. Strobes on those cycles count; strobes in other states are ignored.
//    timer==0 -> DONE; o_count <= final count (including a strobe on the last gate cycle).
//    o_ovf <= flag; o_valid <= 1 on entry.
//   DONE: o_valid, o_count, o_ovf held stable until i_ready=1 (handshake cycle).
//    Handshake with i_auto=1 -> ARM; with i_auto=0 -> IDLE. o_valid deasserts in handshake+1 cycle.
//  Counter: saturates at all-ones; increment attempted at all-ones sets flag (o_ovf), no wrap.
//  i_start while o_busy: ignored (no queuing). i_start with i_auto in IDLE: single ARM entry.
//  i_abort in ARM/GATE/DONE: -> IDLE next cycle; o_valid, o_gate cleared; o_count keeps last value.
//   i_abort has priority over i_ready and over timer expiry in the same cycle.
//  i_gate_sel changes outside ARM have no effect on the running gate.
//  Frequency = o_count * 50e6 / GATEsel; scaling is done by the consumer, not this block.
// TESTING
//  (GATE3 overridden to 50_000; fx = 100 kHz, i.e. 50 MHz / 500)
//  1 Single shot: i_gate_sel=3, i_start pulse, i_ready=1.
//    -> o_gate high 50_000 cycles; o_valid 1 cycle; o_count = 100 (+/-1); o_ovf=0.
//  2 Backpressure: i_ready=0 for 200 cycles after o_valid.
//    -> o_valid/o_count stable; no rearm; accepted on first i_ready=1; IDLE next.
//  3 Auto mode: i_auto=1, i_ready=1.
//    -> back-to-back results; ARM follows each handshake by 1 cycle; each count 100 (+/-1).
//  4 Abort: i_abort at gate cycle 20_000. -> IDLE next cycle; no o_valid; new i_start measures normally.
//  5 Overflow: CNT_W=4, fx=1 MHz, GATE3=1000. -> o_count=15, o_ovf=1; next measurement clears o_ovf.
//  6 Async reset mid-GATE: grst_n low 3 cycles. -> all outputs 0 immediately; IDLE; no spurious o_valid.

Source files
------------

// File: rtl/freq_meas_sequencer.sv
// freq_meas_sequencer: one gated edge-count measurement of i_fx per request, result offered over valid/ready
// Ports: clkout_50m/grst_n clock and async active-low reset; i_fx clock under test (async);
//   i_start single-shot request; i_auto continuous rearm; i_abort cancel; i_gate_sel gate length select;
//   i_ready result consumer; o_valid/o_count/o_ovf result; o_gate gate window; o_busy ARM/GATE/DONE.
module freq_meas_sequencer #(
  parameter int CNT_W = 32,
  parameter int GATE0 = 50_000_000,
  parameter int GATE1 = 5_000_000,
  parameter int GATE2 = 500_000,
  parameter int GATE3 = 50_000
) (
  input  logic             clkout_50m,
  input  logic             grst_n,
  input  logic             i_fx,
  input  logic             i_start,
  input  logic             i_auto,
  input  logic             i_abort,
  input  logic [1:0]       i_gate_sel,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ovf,
  output logic             o_gate,
  output logic             o_busy
);
  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;
  state_t state;
  logic fx_s1, fx_s2, fx_dly, strobe;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic flag, flag_nxt;
  logic [31:0] timer, gate_len;
  assign strobe = fx_s2 & ~fx_dly;
  // saturating count: an edge arriving at all-ones is recorded as overflow instead of wrapping
  always_comb begin
    gate_len = i_gate_sel == 2'd0 ? 32'(GATE0) :
               i_gate_sel == 2'd1 ? 32'(GATE1) :
               i_gate_sel == 2'd2 ? 32'(GATE2) : 32'(GATE3);
    cnt_nxt  = cnt + CNT_W'(strobe & ~(&cnt));
    flag_nxt = flag | (strobe & (&cnt));
  end
  always_ff @(posedge clkout_50m or negedge grst_n) begin
    if (!grst_n) begin
      state   <= IDLE;
      fx_s1   <= 1'b0;
      fx_s2   <= 1'b0;
      fx_dly  <= 1'b0;
      cnt     <= '0;
      flag    <= 1'b0;
      timer   <= '0;
      o_valid <= 1'b0;
      o_count <= '0;
      o_ovf   <= 1'b0;
      o_gate  <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      fx_s1  <= i_fx;
      fx_s2  <= fx_s1;
      fx_dly <= fx_s2;
      case (state)
        IDLE: if (i_start | i_auto) begin
          state  <= ARM;
          o_busy <= 1'b1;
        end
        ARM: if (i_abort) begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end else begin
          cnt    <= '0;
          flag   <= 1'b0;
          timer  <= gate_len - 32'd1;
          state  <= GATE;
          o_gate <= 1'b1;
        end
        GATE: if (i_abort) begin
          state  <= IDLE;
          o_gate <= 1'b0;
          o_busy <= 1'b0;
        end else begin
          cnt   <= cnt_nxt;
          flag  <= flag_nxt;
          timer <= timer - 32'd1;
          // last gate cycle: publish the count including this cycle's strobe
          if (timer == '0) begin
            state   <= DONE;
            o_gate  <= 1'b0;
            o_valid <= 1'b1;
            o_count <= cnt_nxt;
            o_ovf   <= flag_nxt;
          end
        end
        DONE: if (i_abort) begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end else if (i_ready) begin
          o_valid <= 1'b0;
          state   <= i_auto ? ARM : IDLE;
          o_busy  <= i_auto;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_freq_meas_sequencer.sv
// tb_freq_meas_sequencer: randomized measurements of freq_meas_sequencer against an edge-history reference model
module tb_freq_meas_sequencer;
  localparam int W = 5, G0 = 200, G1 = 100, G2 = 40, G3 = 20, MAX = 31;
  logic clkout_50m = 1'b0, grst_n = 1'b1, i_fx = 1'b0;
  logic i_start = 1'b0, i_auto = 1'b0, i_abort = 1'b0, i_ready = 1'b0;
  logic [1:0] i_gate_sel = 2'd0;
  logic o_valid, o_ovf, o_gate, o_busy;
  logic [W-1:0] o_count;
  int checks = 0, failures = 0, cyc = 0, fx_p = 0, last_cnt = 0;
  bit hist [65536];
  freq_meas_sequencer #(.CNT_W(W), .GATE0(G0), .GATE1(G1), .GATE2(G2), .GATE3(G3)) dut (
    .clkout_50m(clkout_50m), .grst_n(grst_n), .i_fx(i_fx), .i_start(i_start), .i_auto(i_auto),
    .i_abort(i_abort), .i_gate_sel(i_gate_sel), .i_ready(i_ready), .o_valid(o_valid),
    .o_count(o_count), .o_ovf(o_ovf), .o_gate(o_gate), .o_busy(o_busy)
  );
  always #5 clkout_50m = ~clkout_50m;
  // hist[n] is the i_fx level seen at rising edge number n; cyc is the number of the next edge
  initial forever begin
    @(posedge clkout_50m);
    hist[cyc] = i_fx;
    cyc++;
  end
  // fx_p==0: random level every cycle, else square wave toggling every fx_p cycles
  initial forever begin
    @(negedge clkout_50m);
    i_fx = fx_p == 0 ? 1'($urandom_range(0, 1)) : ((cyc / fx_p) % 2 == 1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int glen(input int sel);
    return sel == 0 ? G0 : sel == 1 ? G1 : sel == 2 ? G2 : G3;
  endfunction
  // a measurement requested at edge s counts i_fx rises first sampled at edges s .. s+g-1
  task automatic model(input int s, input int g, output int c, output bit ov);
    int raw = 0;
    for (int k = s; k < s + g; k++) raw += int'(hist[k] & !hist[k-1]);
    c  = raw > MAX ? MAX : raw;
    ov = raw > MAX;
  endtask
  task automatic go(input int sel, input bit au, output int s);
    i_gate_sel = 2'(sel);
    i_auto = au;
    i_start = 1'b1;
    s = cyc;
    @(negedge clkout_50m);
    i_start = 1'b0;
  endtask
  // entered at the negedge with cyc == s+1; returns the handshake edge number in h
  task automatic meas(input int s, input int sel, input int bp, input bit auto_next,
                      input int next_sel, input bit abort_end, output int h);
    int g = glen(sel), c, n = 0;
    bit ov;
    while (!o_valid && cyc < s + g + 10) begin
      n += int'(o_gate);
      if (cyc >= s + 2) i_gate_sel = 2'($urandom);
      i_start = $urandom_range(0, 7) == 0;
      @(negedge clkout_50m);
    end
    i_start = 1'b0;
    model(s, g, c, ov);
    check("valid_latency", cyc, s + g + 2);
    check("gate_cycles", n, g);
    check("count", o_count, c);
    check("ovf", o_ovf, ov);
    check("busy_done", o_busy, 1);
    repeat (bp) begin
      @(negedge clkout_50m);
      check("hold_valid", o_valid, 1);
      check("hold_count", o_count, c);
    end
    h = cyc;
    i_ready = 1'b1;
    if (abort_end) begin
      i_abort = 1'b1;
      i_auto = 1'b1;
    end else begin
      i_auto = auto_next;
      if (auto_next) i_gate_sel = 2'(next_sel);
    end
    @(negedge clkout_50m);
    i_ready = 1'b0;
    i_abort = 1'b0;
    if (abort_end) i_auto = 1'b0;
    check("valid_drop", o_valid, 0);
    check("busy_after", o_busy, !abort_end && auto_next);
    check("count_kept", o_count, c);
    last_cnt = c;
  endtask
  task automatic abort_run(input int sel, input int d);
    int s, v = 0;
    go(sel, 1'b0, s);
    repeat (d) @(negedge clkout_50m);
    i_abort = 1'b1;
    @(negedge clkout_50m);
    i_abort = 1'b0;
    check("abort_busy", o_busy, 0);
    check("abort_gate", o_gate, 0);
    check("abort_valid", o_valid, 0);
    check("abort_count", o_count, last_cnt);
    repeat (glen(sel) + 5) begin
      @(negedge clkout_50m);
      v |= int'(o_valid | o_busy);
    end
    check("abort_quiet", v, 0);
  endtask
  initial begin
    int s, h, sel, nsel, v;
    #1 grst_n = 1'b0;
    repeat (3) @(negedge clkout_50m);
    check("reset_outputs", {o_valid, o_count, o_ovf, o_gate, o_busy}, 0);
    grst_n = 1'b1;
    repeat (5) @(negedge clkout_50m);
    for (int i = 0; i < 24; i++) begin
      fx_p = $urandom_range(0, 7);
      sel = $urandom_range(0, 3);
      go(sel, 1'b0, s);
      meas(s, sel, $urandom_range(0, 2) == 0 ? $urandom_range(1, 8) : 0, 1'b0, 0, 1'b0, h);
      repeat ($urandom_range(0, 3)) @(negedge clkout_50m);
    end
    fx_p = 0;
    go(0, 1'b0, s);
    meas(s, 0, 0, 1'b0, 0, 1'b0, h);
    fx_p = 5;
    go(3, 1'b0, s);
    meas(s, 3, 0, 1'b0, 0, 1'b0, h);
    fx_p = 3;
    sel = 3;
    go(sel, 1'b1, s);
    for (int i = 0; i < 5; i++) begin
      nsel = $urandom_range(0, 3);
      meas(s, sel, i == 2 ? 5 : 0, i < 4, nsel, 1'b0, h);
      s = h;
      sel = nsel;
    end
    for (int i = 0; i < 4; i++) begin
      fx_p = $urandom_range(0, 4);
      sel = $urandom_range(1, 3);
      abort_run(sel, $urandom_range(0, glen(sel)));
    end
    fx_p = 2;
    abort_run(3, G3);
    sel = 2;
    go(sel, 1'b0, s);
    meas(s, sel, 2, 1'b0, 0, 1'b1, h);
    go(2, 1'b0, s);
    repeat (10) @(negedge clkout_50m);
    #2 grst_n = 1'b0;
    #1 check("async_reset", {o_valid, o_count, o_ovf, o_gate, o_busy}, 0);
    repeat (3) @(negedge clkout_50m);
    grst_n = 1'b1;
    last_cnt = 0;
    v = 0;
    repeat (60) begin
      @(negedge clkout_50m);
      v |= int'(o_valid | o_busy);
    end
    check("reset_quiet", v, 0);
    fx_p = 4;
    go(1, 1'b0, s);
    meas(s, 1, 3, 1'b0, 0, 1'b0, h);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
